// File: rtl/truth_table_capture.sv
// Truth-table sweeper: walks every input combination of an external combinational
// function, waits SETTLE cycles per vector, and records its output as a minterm mask.
module truth_table_capture #(
    parameter int N_INPUTS = 4,
    parameter int SETTLE   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [N_INPUTS-1:0]        abcd,
    input  logic                       y_in,
    output logic                       busy,
    output logic                       done,
    output logic [(1<<N_INPUTS)-1:0]   table_out,
    output logic [N_INPUTS:0]          minterm_count
);

    localparam int                  DEPTH      = 1 << N_INPUTS;
    localparam int                  CW         = N_INPUTS + 1;
    localparam logic [N_INPUTS-1:0] LAST_IDX   = N_INPUTS'(DEPTH - 1);
    localparam logic [3:0]          SETTLE_LIM = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, SETTLE_WAIT, CAPTURE, DONE} state_t;

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] abcd_q, abcd_d;
    logic [3:0]          settle_q, settle_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DEPTH-1:0]    table_q, table_d;
    logic [CW-1:0]       count_q, count_d;

    // abcd doubles as the sweep index: the vector on the bus is always the one being captured.
    always_comb begin
        state_d  = state_q;
        abcd_d   = abcd_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;
        table_d  = table_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    abcd_d   = '0;
                    table_d  = '0;
                    count_d  = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    state_d  = (SETTLE == 0) ? CAPTURE : SETTLE_WAIT;
                end
            end
            SETTLE_WAIT: begin
                settle_d = settle_q + 4'd1;
                if (settle_q + 4'd1 == SETTLE_LIM) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                table_d[abcd_q] = y_in;
                count_d         = count_q + CW'(y_in);
                if (abcd_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    // Terminal index is caught above, so this increment never wraps.
                    abcd_d   = abcd_q + 1'b1;
                    settle_d = '0;
                    state_d  = (SETTLE == 0) ? CAPTURE : SETTLE_WAIT;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            abcd_q   <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            table_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            abcd_q   <= abcd_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            table_q  <= table_d;
            count_q  <= count_d;
        end
    end

    assign abcd          = abcd_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign table_out     = table_q;
    assign minterm_count = count_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: three sweepers (N3/S1, N4/S0, N4/S2) checked each cycle
// against a timeline model of the sweep, plus literal tables, counts and latencies.
module tb_truth_table_capture;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [1:0] sel2 = 2'd0;

    logic [2:0]  abcd0;
    logic [3:0]  abcd1, abcd2;
    logic        y0, y1, y2;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic [7:0]  tab0;
    logic [15:0] tab1, tab2;
    logic [3:0]  cnt0;
    logic [4:0]  cnt1, cnt2;

    always #5 clk = ~clk;

    assign y0 = ~abcd0[1];
    assign y1 = (abcd1[3] & ~abcd1[0]) | (abcd1[2] & abcd1[0]) | (abcd1[3] & abcd1[1]);
    assign y2 = (sel2 == 2'd2) ? ^abcd2 : sel2[0];

    truth_table_capture #(.N_INPUTS(3), .SETTLE(1)) u0 (
        .clk(clk), .reset(reset), .start(start0), .abcd(abcd0), .y_in(y0),
        .busy(busy0), .done(done0), .table_out(tab0), .minterm_count(cnt0));
    truth_table_capture #(.N_INPUTS(4), .SETTLE(0)) u1 (
        .clk(clk), .reset(reset), .start(start1), .abcd(abcd1), .y_in(y1),
        .busy(busy1), .done(done1), .table_out(tab1), .minterm_count(cnt1));
    truth_table_capture #(.N_INPUTS(4), .SETTLE(2)) u2 (
        .clk(clk), .reset(reset), .start(start2), .abcd(abcd2), .y_in(y2),
        .busy(busy2), .done(done2), .table_out(tab2), .minterm_count(cnt2));

    logic [2:0][3:0]  act_abcd;
    logic [2:0]       act_busy, act_done;
    logic [2:0][15:0] act_tab;
    logic [2:0][7:0]  act_cnt;
    assign act_abcd = {abcd2, abcd1, 4'(abcd0)};
    assign act_busy = {busy2, busy1, busy0};
    assign act_done = {done2, done1, done0};
    assign act_tab  = {tab2, tab1, 16'(tab0)};
    assign act_cnt  = {8'(cnt2), 8'(cnt1), 8'(cnt0)};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s u%0d: got %0h expected %0h (t=%0t)", nm, u, act, exp, $time);
    endtask

    function automatic int depth_of(input int u);
        return (u == 0) ? 8 : 16;
    endfunction

    function automatic int settle_of(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 0 : 2);
    endfunction

    // Reference functions evaluated from the minterm index (A = index MSB).
    function automatic bit ref_y(input int u, input int i, input logic [1:0] sel);
        bit a, b, c, d;
        a = i[3]; b = i[2]; c = i[1]; d = i[0];
        case (u)
            0:       return !i[1];
            1:       return (a & !d) | (b & d) | (a & c);
            default: return (sel == 2'd2) ? (a ^ b ^ c ^ d) : sel[0];
        endcase
    endfunction

    function automatic logic [15:0] full_tab(input int u, input logic [1:0] sel);
        logic [15:0] t = '0;
        for (int i = 0; i < depth_of(u); i++) t[i] = ref_y(u, i, sel);
        return t;
    endfunction

    function automatic logic start_of(input int u);
        return (u == 0) ? start0 : ((u == 1) ? start1 : start2);
    endfunction

    // Timeline model: a sweep accepted at edge k runs depth*(settle+1) edges, then done, then idle.
    int          cyc = 0;
    bit          active [3];
    int          acc_k [3];
    logic [15:0] full [3];

    initial begin
        for (int u = 0; u < 3; u++) begin active[u] = 0; acc_k[u] = 0; full[u] = '0; end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int u = 0; u < 3; u++) active[u] = 0;
            end else begin
                cyc++;
                for (int u = 0; u < 3; u++) begin
                    if (start_of(u) &&
                        !(active[u] && (cyc - acc_k[u]) <= depth_of(u) * (settle_of(u) + 1) + 1)) begin
                        active[u] = 1;
                        acc_k[u]  = cyc;
                        full[u]   = full_tab(u, sel2);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                int per, tv, rel, cap, ea;
                bit eb, ed;
                logic [15:0] m, et;
                per = settle_of(u) + 1;
                tv  = depth_of(u) * per;
                eb = 0; ed = 0; ea = 0; cap = 0;
                if (active[u]) begin
                    rel = cyc - acc_k[u];
                    if (rel < tv) begin eb = 1; ea = rel / per; cap = rel / per; end
                    else begin ed = (rel == tv); ea = depth_of(u) - 1; cap = depth_of(u); end
                end
                m = '0;
                for (int j = 0; j < cap; j++) m[j] = 1'b1;
                et = full[u] & m;
                chk("abcd", u, 32'(act_abcd[u]), 32'(ea));
                chk("busy", u, 32'(act_busy[u]), 32'(eb));
                chk("done", u, 32'(act_done[u]), 32'(ed));
                chk("table", u, 32'(act_tab[u]), 32'(et));
                chk("count", u, 32'(act_cnt[u]), 32'($countones(et)));
            end
        end
    end

    task automatic set_start(input int u, input logic v);
        case (u)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic sweep(input int u, input int p1, input int p2, input bit at_done,
                         input logic [15:0] exp_tab, input int exp_cnt, input int exp_lat);
        int lat;
        @(negedge clk);
        set_start(u, 1'b1);
        @(posedge clk); #1;
        set_start(u, 1'b0);
        lat = 0;
        while (!act_done[u] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            set_start(u, (lat == p1 || lat == p2));
        end
        set_start(u, 1'b0);
        chk("latency", u, 32'(lat), 32'(exp_lat));
        chk("lit_table", u, 32'(act_tab[u]), 32'(exp_tab));
        chk("lit_count", u, 32'(act_cnt[u]), 32'(exp_cnt));
        if (at_done) begin
            set_start(u, 1'b1);
            @(posedge clk); #1;
            set_start(u, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, lat2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 1, 32'(busy1), 32'h0);
        chk("rst_table", 1, 32'(tab1), 32'h0);
        repeat (2) @(posedge clk);

        sweep(0, -1, -1, 1'b0, 16'h0033, 4, 16);
        sweep(1, -1, -1, 1'b0, 16'hFDA0, 9, 16);
        sel2 = 2'd0;
        sweep(2, -1, -1, 1'b0, 16'h0000, 0, 48);
        sel2 = 2'd1;
        sweep(2, -1, -1, 1'b0, 16'hFFFF, 16, 48);
        sel2 = 2'd2;
        sweep(2, 5, 20, 1'b1, 16'h6996, 8, 48);

        // Start held high: the second sweep starts in the IDLE cycle after DONE.
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!done0 && lat < 300) begin @(posedge clk); #1; lat++; end
        chk("b2b_lat1", 0, 32'(lat), 32'd16);
        @(posedge clk); #1;
        lat2 = 1;
        while (!done0 && lat2 < 300) begin @(posedge clk); #1; lat2++; end
        start0 = 1'b0;
        chk("b2b_lat2", 0, 32'(lat2), 32'd18);
        chk("b2b_table", 0, 32'(tab0), 32'h33);
        chk("b2b_count", 0, 32'(cnt0), 32'd4);
        repeat (3) @(posedge clk);

        // Asynchronous reset mid-sweep, once index 7 is on the bus.
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 0;
        while (abcd2 != 4'd7 && lat < 300) begin @(posedge clk); #1; lat++; end
        chk("reach_idx7", 2, 32'(abcd2), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_abcd", 2, 32'(abcd2), 32'h0);
        chk("arst_busy", 2, 32'(busy2), 32'h0);
        chk("arst_table", 2, 32'(tab2), 32'h0);
        chk("arst_count", 2, 32'(cnt2), 32'h0);
        chk("arst_abcd", 1, 32'(abcd1), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        sweep(2, -1, -1, 1'b0, 16'h6996, 8, 48);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
